mdu_ctrl: RTL and testbench

Iterative multiply/divide controller for the pipelined MIPS core. It sequences a 32-iteration shift-add multiplier and a restoring divider that share one accumulator datapath, and writes HI/LO on completion. It drives `busy` so the ID-stage control logic can stall dependent `mfhi`/`mflo` and new mul/div ops. It sits beside the EXE-stage ALU, and the EXE stage issues operations into it.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_if.sv | 30 +++
 rtl/mdu_iter.sv | 78 +++++++
 rtl/mdu_ctrl.sv | 156 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: operation encodings,
// controller state encoding and the default operand width.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_RUN  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } mdu_state_e;

   function automatic logic op_is_signed(mdu_op_e op);
      return ~op[0];
   endfunction

   function automatic logic op_is_div(mdu_op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the EXE stage (master) and the multiply/divide
// controller (slave).
interface mdu_if
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) ();

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             dz;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, hi, lo, dz
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, hi, lo, dz
   );

endinterface

// File: rtl/mdu_iter.sv
// Shared accumulator datapath: shift-add multiply step and, when MDU_DIV_EN is
// defined, a restoring divide step; applies the final sign correction.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             is_div_i,
   input  logic             fix_i,
   input  logic             neg_res_i,
   input  logic             neg_rem_i,
   input  logic [WIDTH-1:0] mag_a_i,
   input  logic [WIDTH-1:0] mag_b_i,
   output logic [WIDTH-1:0] res_hi_o,
   output logic [WIDTH-1:0] res_lo_o
);

   // acc: product high half / partial remainder; aux: multiplier / quotient
   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]   aux_q;
   logic [WIDTH-1:0]   mcand_q;

   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign sum = {1'b0, acc_q} + (aux_q[0] ? {1'b0, mcand_q} : '0);

`ifdef MDU_DIV_EN
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;
   assign rem_sh = {acc_q, aux_q[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, mcand_q};
`endif

   always_comb begin
      prod     = {acc_q, aux_q};
      prod_fix = neg_res_i ? -prod : prod;
      quo_fix  = neg_res_i ? -aux_q : aux_q;
      rem_fix  = neg_rem_i ? -acc_q : acc_q;
      res_hi_o = is_div_i ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
      res_lo_o = is_div_i ? quo_fix : prod_fix[WIDTH-1:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q   <= '0;
         aux_q   <= '0;
         mcand_q <= '0;
      end else if (load_i) begin
         acc_q   <= '0;
         aux_q   <= is_div_i ? mag_a_i : mag_b_i;
         mcand_q <= is_div_i ? mag_b_i : mag_a_i;
      end else if (step_i) begin
`ifdef MDU_DIV_EN
         if (is_div_i) begin
            // top bit of diff set means the trial subtract went negative: restore
            acc_q <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            aux_q <= {aux_q[WIDTH-2:0], ~diff[WIDTH]};
         end else
`endif
         begin
            acc_q <= sum[WIDTH:1];
            aux_q <= {sum[0], aux_q[WIDTH-1:1]};
         end
      end else if (fix_i) begin
         acc_q <= res_hi_o;
         aux_q <= res_lo_o;
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the EXE stage; owns HI/LO, busy/done and the
// zero-divisor flag. Divide support is compiled in only with MDU_DIV_EN.
//
// state | meaning
// IDLE  | waiting for start
// PREP  | take operand magnitudes and signs, load datapath (or zero-divisor exit)
// RUN   | one multiply/divide iteration per cycle, WIDTH cycles
// FIX   | sign-correct and write HI/LO
// DONE  | one-cycle done pulse, back-to-back start accepted here
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input logic   clock,
   input logic   reset,
   mdu_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);

   mdu_state_e       state_q;
   mdu_op_e          op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             neg_res_q;
   logic             neg_rem_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             dz_q;
   logic             busy_q;
   logic             done_q;

   logic             sgn_op;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic             load;
   logic             step;
   logic             fix;
   logic             is_div;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;

   // magnitudes stay unsigned WIDTH bits so the most negative value maps to 2^(WIDTH-1)
   always_comb begin
      sgn_op = op_is_signed(op_q);
      mag_a  = (sgn_op && a_q[WIDTH-1]) ? -a_q : a_q;
      mag_b  = (sgn_op && b_q[WIDTH-1]) ? -b_q : b_q;
   end

   assign is_div = op_is_div(op_q);
   assign load   = (state_q == ST_PREP) && !bus.flush;
   assign step   = (state_q == ST_RUN) && !bus.flush;
   assign fix    = (state_q == ST_FIX) && !bus.flush;

   mdu_iter #(.WIDTH(WIDTH)) u_iter (
      .clock     (clock),
      .reset     (reset),
      .load_i    (load),
      .step_i    (step),
      .is_div_i  (is_div),
      .fix_i     (fix),
      .neg_res_i (neg_res_q),
      .neg_rem_i (neg_rem_q),
      .mag_a_i   (mag_a),
      .mag_b_i   (mag_b),
      .res_hi_o  (res_hi),
      .res_lo_o  (res_lo)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         op_q      <= MDU_MULT;
         a_q       <= '0;
         b_q       <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         count_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         dz_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE, ST_DONE: begin
                  if (bus.start) begin
                     op_q    <= mdu_op_e'(bus.op);
                     a_q     <= bus.a;
                     b_q     <= bus.b;
                     dz_q    <= 1'b0;
                     busy_q  <= 1'b1;
                     state_q <= ST_PREP;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_PREP: begin
                  count_q   <= '0;
                  neg_res_q <= sgn_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                  neg_rem_q <= sgn_op & a_q[WIDTH-1];
                  if (is_div) begin
`ifdef MDU_DIV_EN
                     if (b_q == '0) begin
                        dz_q    <= 1'b1;
                        hi_q    <= a_q;
                        lo_q    <= '1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                     end else begin
                        state_q <= ST_RUN;
                     end
`else
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
`endif
                  end else begin
                     state_q <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  count_q <= count_q + 1'b1;
                  if (count_q == CW'(WIDTH - 1)) state_q <= ST_FIX;
               end
               ST_FIX: begin
                  hi_q    <= res_hi;
                  lo_q    <= res_lo;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.dz   = dz_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized operations
// checked against a plain-arithmetic reference model (honours MDU_DIV_EN).
module tb_mdu_ctrl;
   import mdu_pkg::*;

   localparam int W = MDU_WIDTH;

   logic clock = 1'b0;
   logic reset = 1'b1;

   mdu_if #(.WIDTH(W)) bus ();

   mdu_ctrl #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   logic         m_dz = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: full-width arithmetic, returns the cycle in which done must appear.
   task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
      longint      sa, sb, sq, sr;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lat = 35;
      m_dz = 1'b0;
      case (op)
         2'b00: begin
            p = sa * sb;
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         2'b01: begin
            p = {32'b0, a} * {32'b0, b};
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         default: begin
            lat = 2;
`ifdef MDU_DIV_EN
            if (b == '0) begin
               m_dz = 1'b1;
               m_hi = a;
               m_lo = '1;
            end else begin
               lat = 35;
               if (op == 2'b10) begin
                  sq = sa / sb;
                  sr = sa % sb;
                  m_lo = sq[31:0];
                  m_hi = sr[31:0];
               end else begin
                  m_lo = a / b;
                  m_hi = a % b;
               end
            end
`endif
         end
      endcase
   endtask

   // Called at #1 after an edge with the DUT in IDLE or DONE; returns in the done cycle.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit poke5);
      int lat, got, busy_err, hl_err;
      logic [W-1:0] old_hi, old_lo;
      old_hi = m_hi;
      old_lo = m_lo;
      model(op, a, b, lat);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      got = 0;
      busy_err = 0;
      hl_err = 0;
      for (int k = 1; k <= 60 && got == 0; k++) begin
         @(posedge clock);
         #1;
         bus.start = 1'b0;
         if (bus.done) got = k;
         else begin
            if (bus.busy !== 1'b1) busy_err++;
            if (bus.hi !== old_hi || bus.lo !== old_lo) hl_err++;
         end
         if (poke5 && k == 5) begin
            bus.start = 1'b1;
            bus.op    = 2'b01;
            bus.a     = '1;
            bus.b     = '1;
         end
      end
      chk({tag, " done cycle"}, 64'(got), 64'(lat));
      chk({tag, " busy while running"}, 64'(busy_err), 64'd0);
      chk({tag, " busy at done"}, 64'(bus.busy), 64'd0);
      chk({tag, " hi/lo stable before done"}, 64'(hl_err), 64'd0);
      chk({tag, " hi"}, 64'(bus.hi), 64'(m_hi));
      chk({tag, " lo"}, 64'(bus.lo), 64'(m_lo));
      chk({tag, " dz"}, 64'(bus.dz), 64'(m_dz));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      int lat, done_seen, gap;
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;

      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      bus.flush = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      chk("reset hi", 64'(bus.hi), 64'd0);
      chk("reset lo", 64'(bus.lo), 64'd0);
      chk("reset busy", 64'(bus.busy), 64'd0);
      chk("reset done", 64'(bus.done), 64'd0);
      chk("reset dz", 64'(bus.dz), 64'd0);
      idle(2);

      run_op("mult -3*5, start@5 ignored", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1);
      idle(2);
      run_op("multu ff*ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("b2b div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
      idle(1);
      run_op("div minint/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      idle(1);
      run_op("divu 7/0", 2'b11, 32'd7, 32'd0, 1'b0);
      idle(2);

      // flush+start together in IDLE: start dropped, nothing changes
      bus.flush = 1'b1;
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.a     = 32'd9;
      bus.b     = 32'd9;
      idle(1);
      bus.flush = 1'b0;
      bus.start = 1'b0;
      chk("flush+start busy", 64'(bus.busy), 64'd0);
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         idle(1);
         if (bus.done) done_seen++;
      end
      chk("flush+start no done", 64'(done_seen), 64'd0);
      chk("flush+start hi", 64'(bus.hi), 64'(m_hi));
      chk("flush+start lo", 64'(bus.lo), 64'(m_lo));
      chk("flush+start dz", 64'(bus.dz), 64'(m_dz));

      // mult flushed at cycle 10; accepted start already cleared dz
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.a     = 32'd1234;
      bus.b     = 32'd5678;
      m_dz      = 1'b0;
      done_seen = 0;
      for (int k = 1; k <= 11; k++) begin
         idle(1);
         bus.start = 1'b0;
         if (bus.done) done_seen++;
         if (k == 9) chk("flush: busy before flush", 64'(bus.busy), 64'd1);
         bus.flush = (k == 10);
      end
      chk("flush: busy at cycle 11", 64'(bus.busy), 64'd0);
      for (int k = 0; k < 40; k++) begin
         idle(1);
         if (bus.done) done_seen++;
      end
      chk("flush: no done", 64'(done_seen), 64'd0);
      chk("flush: hi kept", 64'(bus.hi), 64'(m_hi));
      chk("flush: lo kept", 64'(bus.lo), 64'(m_lo));
      chk("flush: dz", 64'(bus.dz), 64'(m_dz));

      for (int n = 0; n < 40; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: begin ra = 32'h8000_0000; rb = '1; end
            2: rb = 32'($urandom_range(1, 9));
            default: ;
         endcase
         run_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb, 1'b0);
         gap = $urandom_range(0, 2);
         idle(gap);
      end

      lat = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
